dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the in-order pipeline's dmem port: a 64-word × 32-bit array serving CPU loads (combinational read) and stores (one per cycle, never stalled). A second req/ack host port (testbench loader / debug) reads and writes the same array through a small FSM. CPU traffic always has priority, and host accesses slip into idle write cycles. The block sits beside the CPU top, wired directly to `dmem_addr`, `dmem_wdata`, `dmem_w_en` and `dmem_rdata`.

## Interface
- `WIDTH`, 32, data word width
- `DEPTH`, 64, number of words
- `ADDR_W`, 6, word-address width; log2(DEPTH)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `dmem_addr`  in  ADDR_W  CPU word address
- `dmem_w_en`  in  1  CPU store strobe; the store commits at the clock edge
- `dmem_wdata`  in  WIDTH  CPU store data
- `dmem_rdata`  out  WIDTH  combinational read of `mem[dmem_addr]`
- `host_req`  in  1  host request; held until `host_ack`
- `host_we`  in  1  1 = write, 0 = read; stable while `host_req`
- `host_addr`  in  ADDR_W  host word address; stable while `host_req`
- `host_wdata`  in  WIDTH  host write data; stable while `host_req`
- `host_ack`  out  1  one-cycle completion pulse
- `host_rdata`  out  WIDTH  read data; valid when `host_ack`=1, holds until the next read ack

## Operation
- **CPU port:**
  - Stateless.
  - `dmem_rdata` = array content at `dmem_addr`, pre-edge value.
  - A store in the same cycle is not bypassed to `dmem_rdata`.
- **Host FSM states:** IDLE, WAIT, RESP.
- **IDLE**, `host_req`=1:
  - Read: accepted immediately; goes to RESP.
  - Write with `dmem_w_en`=0: accepted and the array is written at this edge; goes to RESP.
  - Write with `dmem_w_en`=1: goes to WAIT, nothing is written.
- **WAIT:**
  - Stays in WAIT while `dmem_w_en`=1.
  - The first cycle with `dmem_w_en`=0 commits the host write and goes to RESP.
  - No bound on waiting; the CPU is never stalled.
- **RESP:** `host_ack`=1 for exactly this cycle, then IDLE.
- **Host read capture:**
  - `host_rdata` is registered on the accept edge.
  - If the CPU writes the same address on that edge, `host_rdata` takes `dmem_wdata` (write-through bypass).
- **Simultaneous host write + CPU read, same address:** the CPU sees the old value that cycle and the new value from the next cycle.
- **Protocol errors:** `host_req` deasserted before ack is a protocol violation; the FSM still completes the accepted operation.
- **Address width:** addresses are exactly ADDR_W bits; no out-of-range case.

## Timing
- Reset values: FSM = IDLE, `host_ack`=0, `host_rdata`=0.
  - `dmem_rdata` follows the array (see Configuration).
- Host read latency: accept at edge T, `host_ack`=1 in cycle T+1, IDLE at T+2.
  - Next request is sampled at T+2; maximum one host op per 2 cycles.
- Host write latency: 2 cycles if uncontended; 2 + N cycles with N consecutive CPU-store cycles.
- Reset asserted mid-operation:
  - FSM goes to IDLE and ack is dropped immediately.
  - A write already committed stays; a write in WAIT is discarded.
- Array write port: at most one write per edge (CPU or host, never both).

## Configuration
- Macro: `DMEM_VALID_CLEAR_EN`.
- **Defined:**
  - A DEPTH-bit valid vector is cleared by reset and set on any write to that word.
  - Reads of an invalid word return 0 on both `dmem_rdata` and `host_rdata`.
  - The memory appears zeroed after every reset.
- **Undefined:** no valid vector; array contents are unreset and read back whatever the storage holds.

## Structure
- Package `dmem_pkg`: host FSM state enum (IDLE/WAIT/RESP), DEPTH/ADDR_W/WIDTH localparams.
- Sub-module `dmem_array`:
  - One write port.
  - One asynchronous read port (CPU).
  - One read port feeding the host capture register.
  - Optional valid vector inside.
- Top holds the FSM, write-port mux (CPU priority) and bypass compare.

## Test plan
- After reset, CPU store addr 5 = 0xDEADBEEF; next cycle `dmem_rdata` at addr 5 = 0xDEADBEEF.
- Host write addr 10 = 0x12345678 with CPU idle → ack 2 cycles after req; CPU reads 0x12345678.
- Host write while CPU stores for 3 consecutive cycles → ack exactly 5 cycles after req; both host and CPU data present at their addresses.
- Host read addr 7 on the edge the CPU stores 0xA5A5A5A5 to addr 7 → `host_rdata`=0xA5A5A5A5 with ack.
- Host write in WAIT, then reset asserted → ack never pulses; target word unchanged (reads 0 with `DMEM_VALID_CLEAR_EN`).
- With `DMEM_VALID_CLEAR_EN`: write all 64 words, reset, read all via both ports → all 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and host FSM state type for the dmem responder.
package dmem_pkg;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } host_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word array: one write port, async CPU read port, host read port.
// DMEM_VALID_CLEAR_EN adds a reset-cleared per-word valid vector that masks reads to zero.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int WIDTH  = dmem_pkg::WIDTH,
  parameter int DEPTH  = dmem_pkg::DEPTH,
  parameter int ADDR_W = dmem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [WIDTH-1:0]  cpu_rdata,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [WIDTH-1:0]  host_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef DMEM_VALID_CLEAR_EN
  logic [DEPTH-1:0] valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (we) begin
      valid[waddr] <= 1'b1;
    end
  end

  // Words never written since reset read as zero on both ports.
  assign cpu_rdata  = valid[cpu_addr]  ? mem[cpu_addr]  : '0;
  assign host_rdata = valid[host_addr] ? mem[host_addr] : '0;
`else
  logic unused_rst_n;
  assign unused_rst_n = rst_n;

  assign cpu_rdata  = mem[cpu_addr];
  assign host_rdata = mem[host_addr];
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stateless CPU port with priority, host req/ack port served in idle write cycles.
// Optional DMEM_VALID_CLEAR_EN makes the array read as zero after every reset.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH  = dmem_pkg::WIDTH,
  parameter int DEPTH  = dmem_pkg::DEPTH,
  parameter int ADDR_W = dmem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_w_en,
  input  logic [WIDTH-1:0]  dmem_wdata,
  output logic [WIDTH-1:0]  dmem_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WIDTH-1:0]  host_wdata,
  output logic              host_ack,
  output logic [WIDTH-1:0]  host_rdata
);

  host_state_t       state, state_nxt;
  logic              accept_rd;
  logic              host_commit;
  logic              load_hold;
  logic [ADDR_W-1:0] hold_addr;
  logic [WIDTH-1:0]  hold_wdata;
  logic [ADDR_W-1:0] commit_addr;
  logic [WIDTH-1:0]  commit_wdata;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [WIDTH-1:0]  arr_wdata;
  logic [WIDTH-1:0]  arr_host_rdata;

  always_comb begin
    state_nxt   = state;
    accept_rd   = 1'b0;
    host_commit = 1'b0;
    load_hold   = 1'b0;
    case (state)
      IDLE: begin
        if (host_req) begin
          if (!host_we) begin
            accept_rd = 1'b1;
            state_nxt = RESP;
          end else if (!dmem_w_en) begin
            host_commit = 1'b1;
            state_nxt   = RESP;
          end else begin
            load_hold = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!dmem_w_en) begin
          host_commit = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A stalled write keeps its own copy so it completes even if the host drops req early.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else if (load_hold) begin
      hold_addr  <= host_addr;
      hold_wdata <= host_wdata;
    end
  end

  assign commit_addr  = (state == WAIT) ? hold_addr  : host_addr;
  assign commit_wdata = (state == WAIT) ? hold_wdata : host_wdata;

  // host_commit is only raised when the CPU is not storing, so the port never sees two writers.
  assign arr_we    = dmem_w_en | host_commit;
  assign arr_waddr = dmem_w_en ? dmem_addr  : commit_addr;
  assign arr_wdata = dmem_w_en ? dmem_wdata : commit_wdata;

  dmem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (reset),
    .we        (arr_we),
    .waddr     (arr_waddr),
    .wdata     (arr_wdata),
    .cpu_addr  (dmem_addr),
    .cpu_rdata (dmem_rdata),
    .host_addr (host_addr),
    .host_rdata(arr_host_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rdata <= '0;
    end else if (accept_rd) begin
      host_rdata <= (dmem_w_en && (dmem_addr == host_addr)) ? dmem_wdata : arr_host_rdata;
    end
  end

  assign host_ack = (state == RESP);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: directed host/CPU vectors, monitor checks on the falling edge.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  dmem_addr = '0;
  logic        dmem_w_en = 1'b0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [5:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_ack;
  logic [31:0] host_rdata;

  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .dmem_addr (dmem_addr),
    .dmem_w_en (dmem_w_en),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_ack  (host_ack),
    .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    int          lat;
  } host_exp_t;

  host_exp_t   host_q[$];
  logic [31:0] cpu_q[$];
  host_exp_t   mon_e;
  logic [31:0] mon_c;
  int          cyc = 0;
  int          req_cyc = 0;
  logic        chk_cpu = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          acks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT shows an ack or a CPU read is flagged.
  always @(negedge clk) begin
    if (host_ack) begin
      acks++;
      checks++;
      if (host_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: ack seen at cycle %0d, required no ack", cyc);
      end else begin
        mon_e = host_q.pop_front();
        if (cyc - req_cyc + 1 != mon_e.lat) begin
          errors++;
          $display("FAIL host_latency: got %0d cycles, required %0d", cyc - req_cyc + 1, mon_e.lat);
        end
        if (mon_e.is_read) begin
          checks++;
          if (host_rdata !== mon_e.rdata) begin
            errors++;
            $display("FAIL host_rdata: got %h, required %h", host_rdata, mon_e.rdata);
          end
        end
      end
    end
    if (chk_cpu) begin
      checks++;
      if (cpu_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_queue: no expectation for addr %0d", dmem_addr);
      end else begin
        mon_c = cpu_q.pop_front();
        if (dmem_rdata !== mon_c) begin
          errors++;
          $display("FAIL cpu_rdata addr %0d: got %h, required %h", dmem_addr, dmem_rdata, mon_c);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic cpu_store(input logic [5:0] a, input logic [31:0] d);
    dmem_addr  = a;
    dmem_wdata = d;
    dmem_w_en  = 1'b1;
    step();
    dmem_w_en  = 1'b0;
  endtask

  task automatic cpu_read(input logic [5:0] a, input logic [31:0] exp);
    dmem_addr = a;
    dmem_w_en = 1'b0;
    cpu_q.push_back(exp);
    chk_cpu = 1'b1;
    step();
    chk_cpu = 1'b0;
  endtask

  task automatic host_start(input logic we, input logic [5:0] a, input logic [31:0] d,
                            input logic [31:0] exp, input int lat);
    host_exp_t e;
    e.is_read = !we;
    e.rdata   = exp;
    e.lat     = lat;
    host_q.push_back(e);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    req_cyc    = cyc;
  endtask

  task automatic host_finish();
    for (int i = 0; i < 20 && !host_ack; i++) step();
    if (!host_ack) begin
      checks++;
      errors++;
      $display("FAIL host_ack_timeout: got no ack, required ack within 20 cycles");
    end
    host_req = 1'b0;
    step();
  endtask

  int acks_before;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {31'b0, host_ack}, 32'h0);
    check("reset_host_rdata", host_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // CPU store then read back
    cpu_store(6'd5, 32'hDEADBEEF);
    cpu_read(6'd5, 32'hDEADBEEF);

    // Uncontended host write, then CPU and host reads
    host_start(1'b1, 6'd10, 32'h12345678, 32'h0, 2);
    host_finish();
    cpu_read(6'd10, 32'h12345678);
    host_start(1'b0, 6'd10, 32'h0, 32'h12345678, 2);
    host_finish();

    // Host write stalled by three consecutive CPU stores
    host_start(1'b1, 6'd40, 32'h40404040, 32'h0, 5);
    dmem_w_en = 1'b1;
    dmem_addr = 6'd41; dmem_wdata = 32'h41414141; step();
    dmem_addr = 6'd42; dmem_wdata = 32'h42424242; step();
    dmem_addr = 6'd43; dmem_wdata = 32'h43434343; step();
    dmem_w_en = 1'b0;
    host_finish();
    cpu_read(6'd40, 32'h40404040);
    cpu_read(6'd41, 32'h41414141);
    cpu_read(6'd43, 32'h43434343);

    // Host read bypasses a same-edge CPU store to the same word
    cpu_store(6'd7, 32'h77777777);
    host_start(1'b0, 6'd7, 32'h0, 32'hA5A5A5A5, 2);
    dmem_addr  = 6'd7;
    dmem_wdata = 32'hA5A5A5A5;
    dmem_w_en  = 1'b1;
    step();
    dmem_w_en  = 1'b0;
    host_finish();
    cpu_read(6'd7, 32'hA5A5A5A5);

    // Host write with CPU reading the same word: old value, then new
    cpu_store(6'd30, 32'h0BADF00D);
    host_start(1'b1, 6'd30, 32'hCAFE0001, 32'h0, 2);
    dmem_addr = 6'd30;
    cpu_q.push_back(32'h0BADF00D);
    chk_cpu = 1'b1;
    step();
    cpu_q.push_back(32'hCAFE0001);
    host_finish();
    chk_cpu = 1'b0;

    // Reset while a host write waits behind CPU stores
    cpu_store(6'd20, 32'h11111111);
    acks_before = acks;
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 6'd20;
    host_wdata = 32'hDEADDEAD;
    dmem_addr  = 6'd21;
    dmem_wdata = 32'h21212121;
    dmem_w_en  = 1'b1;
    step();
    step();
    reset     = 1'b0;
    host_req  = 1'b0;
    dmem_w_en = 1'b0;
    #1;
    check("reset_drops_ack", {31'b0, host_ack}, 32'h0);
    check("reset_clears_host_rdata", host_rdata, 32'h0);
    step();
    step();
    reset = 1'b1;
    step();
    step();
    check("no_ack_after_reset", 32'(acks), 32'(acks_before));
`ifdef DMEM_VALID_CLEAR_EN
    cpu_read(6'd20, 32'h0);
`else
    cpu_read(6'd20, 32'h11111111);
`endif

`ifdef DMEM_VALID_CLEAR_EN
    // Fill every word, reset, and expect zeros from both ports
    for (int i = 0; i < 64; i++) cpu_store(6'(i), 32'(i) * 32'h01010101 + 32'h1);
    cpu_read(6'd63, 32'h3F3F3F40);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    for (int i = 0; i < 64; i++) begin
      cpu_read(6'(i), 32'h0);
      host_start(1'b0, 6'(i), 32'h0, 32'h0, 2);
      host_finish();
    end
`endif

    repeat (3) step();
    check("host_queue_drained", 32'(host_q.size()), 32'h0);
    check("cpu_queue_drained", 32'(cpu_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
